// File: rtl/uart_defines.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | uart_defines : shared UART constants and receiver state encoding  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package uart_defines;

  localparam int CLK_FREQ        = 50_000_000;
  localparam int BAUD_RATE       = 115_200;
  localparam int OVERSAMPLE_RATE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | uart_rx_if : received-byte holding register handshake and flags   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface uart_rx_if
  import uart_defines::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | uart_sync_2ff : generic two-flop synchroniser for async inputs    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic r_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | uart_rx : 8N1 oversampling receiver with valid/ready byte output  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module uart_rx
  import uart_defines::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = OVERSAMPLE_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx,
  uart_rx_if.master  bus
);
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] C_TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_rx_state_t       r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  uart_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // A delivery later in this block overrides the consume-clear.
      if (r_valid && bus.rx_ready) begin
        r_valid <= 1'b0;
      end
      if (sample_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state    <= START;
              r_tick_cnt <= '0;
            end
          end
          START: begin
            if (r_tick_cnt == C_TICK_MID) begin
              r_tick_cnt <= '0;
              if (!w_rx_s) begin
                r_state   <= DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (r_tick_cnt == C_TICK_LAST) begin
              r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_tick_cnt <= '0;
              if (r_bit_cnt == C_BIT_LAST) begin
                r_state   <= STOP;
                r_bit_cnt <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (r_tick_cnt == C_TICK_LAST) begin
              r_tick_cnt <= '0;
              if (w_rx_s) begin
                r_state <= IDLE;
                if (!r_valid || bus.rx_ready) begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= BREAK;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          // Hold off new starts until the line returns high after a break.
          BREAK: begin
            if (w_rx_s) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_uart_rx : directed bench for uart_rx (tick every 4 clk)        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic rx = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int tick_phase = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  bit busy_seen = 1'b0;
  bit valid_seen = 1'b0;
  logic [7:0] got[$];
  int ready_at = -1;
  logic v_pre = 1'b0;
  logic v_post = 1'b0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .rx          (rx),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(int i);
    logic [7:0] r;
    r = 8'hxx;
    if (i < got.size()) r = got[i];
    return r;
  endfunction

  // Monitor the current cycle, then advance one clock; inputs change 1ns after posedge.
  task automatic step();
    if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun) ov_cnt++;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.rx_valid) valid_seen = 1'b1;
    @(posedge clk);
    #1;
    tick_phase  = (tick_phase + 1) % 4;
    sample_tick = (tick_phase == 0);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mon();
    fe_cnt = 0;
    ov_cnt = 0;
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    got.delete();
  endtask

  task automatic consume();
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
  endtask

  // Start bit begins in a phase-2 cycle, so the stop-bit sampling tick is
  // stop-bit cycle 34 and rx_valid first shows in stop-bit cycle 35.
  task automatic send_frame(logic [7:0] b, logic stop, int abort_bit = -1);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    while (tick_phase != 2) step();
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      for (int n = 0; n < 64; n++) begin
        if (k == 9) begin
          if (ready_at >= 0) bus.rx_ready = (n == ready_at);
          if (n == 34) v_pre = bus.rx_valid;
          if (n == 35) v_post = bus.rx_valid;
        end
        if (k == abort_bit && n == 20) begin
          #2;
          rst = 1'b1;
          #1;
          return;
        end
        step();
      end
    end
    if (ready_at >= 0) bus.rx_ready = 1'b0;
  endtask

  initial begin
    bus.rx_ready = 1'b0;
    steps(4);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;
    steps(8);

    // Clean 0xA5 frame, latency and single-cycle consume
    clear_mon();
    send_frame(8'hA5, 1'b1);
    check("a5_valid_before_load", v_pre, 0);
    check("a5_valid_after_load", v_post, 1);
    steps(8);
    check("a5_rx_data", bus.rx_data, 8'hA5);
    check("a5_rx_valid", bus.rx_valid, 1);
    check("a5_frame_err_cnt", fe_cnt, 0);
    check("a5_overrun_cnt", ov_cnt, 0);
    consume();
    check("a5_valid_cleared", bus.rx_valid, 0);
    check("a5_handshake_cnt", got.size(), 1);
    check("a5_handshake_data", got_at(0), 8'hA5);

    // 16-clk low glitch is rejected at mid start bit
    clear_mon();
    while (tick_phase != 2) step();
    rx = 1'b0;
    steps(16);
    rx = 1'b1;
    steps(64);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", bus.busy, 0);
    check("glitch_valid_seen", valid_seen, 0);
    check("glitch_flags", fe_cnt + ov_cnt, 0);

    // Framing error followed by a 3-bit break, then a good frame
    clear_mon();
    send_frame(8'h3C, 1'b0);
    steps(192);
    rx = 1'b1;
    steps(64);
    check("break_frame_err_cnt", fe_cnt, 1);
    check("break_valid_seen", valid_seen, 0);
    check("break_busy_end", bus.busy, 0);
    send_frame(8'h5A, 1'b1);
    steps(8);
    check("after_break_rx_data", bus.rx_data, 8'h5A);
    check("after_break_rx_valid", bus.rx_valid, 1);
    check("after_break_frame_err_cnt", fe_cnt, 1);
    consume();

    // Overrun: second byte dropped while the first is unconsumed
    clear_mon();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    steps(8);
    check("ovr_rx_data", bus.rx_data, 8'h11);
    check("ovr_rx_valid", bus.rx_valid, 1);
    check("ovr_overrun_cnt", ov_cnt, 1);
    check("ovr_frame_err_cnt", fe_cnt, 0);
    consume();
    check("ovr_consumed", got_at(0), 8'h11);

    // Consume on the exact load cycle: new byte replaces old, no overrun
    clear_mon();
    send_frame(8'h11, 1'b1);
    ready_at = 34;
    send_frame(8'h22, 1'b1);
    ready_at = -1;
    steps(8);
    check("swap_rx_data", bus.rx_data, 8'h22);
    check("swap_rx_valid", bus.rx_valid, 1);
    check("swap_overrun_cnt", ov_cnt, 0);
    check("swap_handshake_cnt", got.size(), 1);
    check("swap_handshake_data", got_at(0), 8'h11);

    // Asynchronous reset during data bit 3 of 0x7E, with 0x22 still held
    clear_mon();
    check("prerst_valid_held", bus.rx_valid, 1);
    send_frame(8'h7E, 1'b1, 4);
    check("rst_busy_was_seen", busy_seen, 1);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.frame_err, bus.overrun}, 2'b00);
    steps(3);
    rst = 1'b0;
    rx = 1'b1;
    steps(80);
    clear_mon();
    send_frame(8'h7E, 1'b1);
    steps(8);
    check("post_rst_rx_data", bus.rx_data, 8'h7E);
    check("post_rst_rx_valid", bus.rx_valid, 1);
    check("post_rst_flags", fe_cnt + ov_cnt, 0);
    consume();

    // Back-to-back frames with the consumer always ready
    clear_mon();
    bus.rx_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    steps(16);
    bus.rx_ready = 1'b0;
    check("b2b_handshake_cnt", got.size(), 3);
    check("b2b_byte0", got_at(0), 8'h00);
    check("b2b_byte1", got_at(1), 8'hFF);
    check("b2b_byte2", got_at(2), 8'h55);
    check("b2b_flags", fe_cnt + ov_cnt, 0);
    check("b2b_valid_end", bus.rx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that consumes the 16x oversample tick from the baud generator and deserialises the synchronised rx line into bytes. Frame format is 8N1, LSB first: start bit 0, DATA_BITS data bits, one stop bit 1. Each byte is presented on a valid/ready holding register to the MMIO UART peripheral, with one-cycle framing-error and overrun flags.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
OVERSAMPLE, OVERSAMPLE_RATE (16), sample_tick pulses per bit period; must be even and >= 4

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
sample_tick  input  1  one-clk pulse from baud generator, OVERSAMPLE per bit
rx  input  1  raw serial line, asynchronous to clk
rx_data  output  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  output  1  byte available; held until consumed
rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready both 1
frame_err  output  1  one-clk pulse: stop bit sampled 0
overrun  output  1  one-clk pulse: completed byte dropped because holding register was full
busy  output  1  1 whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high: rst asserted clears all state immediately, without waiting for clk.
- Reset values:
  - outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - internal: state=IDLE, both sync flops=1, tick_cnt=0, bit_cnt=0, shift register=0.
- Reset mid-frame abandons the frame with no flags raised.
- rx passes through a 2-flop synchroniser (rx_s) before any use. All sampling, counting and transitions happen only in cycles where sample_tick=1; other cycles hold state.
- tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS) bits. Both wrap to 0 explicitly, never by overflow.
- States:
  - IDLE: rx_s=0 on a tick -> START, tick_cnt=0.
  - START: at tick_cnt==OVERSAMPLE/2-1 (mid start bit), re-check rx_s. If 0 -> DATA with tick_cnt=0, bit_cnt=0. If 1 -> IDLE (glitch rejected, no flag). Otherwise tick_cnt++.
  - DATA: at tick_cnt==OVERSAMPLE-1 (mid bit), shift rx_s into the MSB of the shift register (right shift, LSB first) and set tick_cnt=0. If bit_cnt==DATA_BITS-1 -> STOP, else bit_cnt++.
  - STOP: at tick_cnt==OVERSAMPLE-1, sample rx_s.
    - If 1: deliver the byte, then -> IDLE.
    - If 0: pulse frame_err, discard the byte, then -> BREAK.
  - BREAK: stay until rx_s=1 on a tick, then -> IDLE. This blocks false starts during a line break.
- Delivery (cycle after the STOP sampling tick):
  - rx_valid=0: load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data, pulse overrun, drop the new byte.
- Handshake: rx_valid&&rx_ready with no concurrent delivery clears rx_valid on the next clk. rx_data is never modified while rx_valid=1 except by the simultaneous load above.
- frame_err and overrun are registered, high exactly one clk. frame_err and delivery are mutually exclusive.
- Latency: rx_valid rises 1 clk after the mid-stop-bit sample_tick, i.e. about 9.5 bit periods after the start edge plus 2 clk of synchroniser delay.

Decomposition:
- uart_defines gains:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - localparam UART_DATA_BITS = 8
- uart_defines already provides OVERSAMPLE_RATE, BAUD_RATE and CLK_FREQ; uart_rx uses these.
- One sub-module: uart_sync_2ff, a generic 2-flop synchroniser with a reset value parameter (1 for rx). It is reusable for other async inputs.

Test Plan:
- Bench drives sample_tick every 4 clk and rx bit periods of 64 clk.
- Frame 0xA5 with stop=1 -> rx_data=0xA5, rx_valid=1, frame_err=0, overrun=0. After rx_ready for 1 clk, rx_valid=0 next clk.
- Low pulse of 4 ticks (16 clk) on idle line -> busy rises then falls, returns to IDLE, rx_valid stays 0, no flags.
- Frame 0x3C with stop=0, then rx held low for 3 bit periods, then frame 0x5A -> one frame_err pulse, no rx_valid for 0x3C, no spurious frame during the low period, then rx_data=0x5A.
- Frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun pulses once after 0x22. Repeat with rx_ready=1 on the exact 0x22 load cycle -> rx_data=0x22, rx_valid stays 1, no overrun.
- rst asserted between clk edges during data bit 3 of 0x7E -> all outputs 0 immediately. After release, a clean 0x7E frame gives rx_data=0x7E with no flags.
- Back-to-back frames 0x00, 0xFF, 0x55 with zero idle gap and rx_ready=1 -> three rx_valid handshakes in order, no errors.
